multi_monitor: RTL

MULTI_MONITOR -- requirements
Module: multi_monitor

---
 rtl/multi_monitor.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/multi_monitor.sv
// multi_monitor: checks a DUT result stream against a golden ALU model.
// Samples are dispatched round-robin into fixed-latency check lanes. Each
// completed check is counted, and every mismatch raises a one-cycle event.
// The first mismatch since reset or clear is captured for debug.
module multi_monitor #(
  parameter int WIDTH     = 32,
  parameter int NUM_LANES = 2,
  parameter int LANE_LAT  = 2,
  parameter int CNT_WIDTH = 16,
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
  localparam int RW = $clog2(LANE_LAT + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_valid,
  input  logic [WIDTH-1:0]     i_dut_ia,
  input  logic [WIDTH-1:0]     i_dut_ib,
  input  logic [WIDTH-1:0]     i_dut_os,
  input  logic [1:0]           i_mode,
  input  logic                 i_clear,
  output logic                 o_event,
  output logic                 o_drop,
  output logic                 o_busy,
  output logic [CNT_WIDTH-1:0] o_chk_count,
  output logic [CNT_WIDTH-1:0] o_err_count,
  output logic                 o_err_sticky,
  output logic [WIDTH-1:0]     o_first_a,
  output logic [WIDTH-1:0]     o_first_b,
  output logic [WIDTH-1:0]     o_first_dut,
  output logic [WIDTH-1:0]     o_first_exp,
  output logic [LW-1:0]        o_first_lane
);

  localparam logic [1:0] MODE_ADD = 2'd0;
  localparam logic [1:0] MODE_SUB = 2'd1;
  localparam logic [1:0] MODE_MUL = 2'd2;

  // Golden operation; all results are naturally truncated to WIDTH bits.
  function automatic logic [WIDTH-1:0] golden(input logic [1:0] m,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (m)
      MODE_ADD: return a + b;
      MODE_SUB: return a - b;
      MODE_MUL: return a * b;
      default:  return a ^ b;
    endcase
  endfunction

  // Lane state: busy flag and remaining edges until completion.
  logic [NUM_LANES-1:0] busy_q, busy_d;
  logic [RW-1:0]        rem_q  [NUM_LANES];
  logic [RW-1:0]        rem_d  [NUM_LANES];
  // Lane payload captured at acceptance.
  logic [WIDTH-1:0]     a_q    [NUM_LANES];
  logic [WIDTH-1:0]     a_d    [NUM_LANES];
  logic [WIDTH-1:0]     b_q    [NUM_LANES];
  logic [WIDTH-1:0]     b_d    [NUM_LANES];
  logic [WIDTH-1:0]     os_q   [NUM_LANES];
  logic [WIDTH-1:0]     os_d   [NUM_LANES];
  logic [1:0]           mode_q [NUM_LANES];
  logic [1:0]           mode_d [NUM_LANES];

  logic [LW-1:0]        ptr_q, ptr_d;
  logic                 lane_free, accept, reject;

  // Completion view (at most one lane completes per edge).
  logic                 comp_any, comp_mis;
  logic [LW-1:0]        comp_lane;
  logic [WIDTH-1:0]     comp_a, comp_b, comp_dut, comp_exp;

  // Result and capture registers.
  logic [CNT_WIDTH-1:0] chk_q, chk_d, err_q, err_d;
  logic                 sticky_q, sticky_d, event_q, event_d, drop_q, drop_d;
  logic [WIDTH-1:0]     fa_q, fa_d, fb_q, fb_d, fdut_q, fdut_d, fexp_q, fexp_d;
  logic [LW-1:0]        flane_q, flane_d;

  // Dispatch decision: the target lane is free if idle or completing now.
  always_comb begin
    lane_free = !busy_q[ptr_q] || (rem_q[ptr_q] == RW'(1));
    accept    = i_valid && lane_free;
    reject    = i_valid && !lane_free;
    ptr_d     = ptr_q;
    if (accept) ptr_d = (ptr_q == LW'(NUM_LANES - 1)) ? '0 : ptr_q + LW'(1);
  end

  // Find the completing lane and evaluate its golden result.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
    comp_any  = 1'b0;
    comp_lane = '0;
    comp_a    = '0;
    comp_b    = '0;
    comp_dut  = '0;
    comp_exp  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (busy_q[i] && rem_q[i] == RW'(1)) begin
        comp_any  = 1'b1;
        comp_lane = LW'(i);
        comp_a    = a_q[i];
        comp_b    = b_q[i];
        comp_dut  = os_q[i];
        comp_exp  = golden(mode_q[i], a_q[i], b_q[i]);
      end
    end
    comp_mis = comp_any && (comp_exp != comp_dut);
  end

  // Lane next state: count down, retire, and load on acceptance.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_LANES; i++) begin
      rem_d[i]  = rem_q[i];
      a_d[i]    = a_q[i];
      b_d[i]    = b_q[i];
      os_d[i]   = os_q[i];
      mode_d[i] = mode_q[i];
      if (busy_q[i]) begin
        if (rem_q[i] == RW'(1)) busy_d[i] = 1'b0;
        else                    rem_d[i]  = rem_q[i] - RW'(1);
      end
      if (accept && ptr_q == LW'(i)) begin
        busy_d[i] = 1'b1;
        rem_d[i]  = RW'(LANE_LAT);
        a_d[i]    = i_dut_ia;
        b_d[i]    = i_dut_ib;
        os_d[i]   = i_dut_os;
        mode_d[i] = i_mode;
      end
    end
  end

  // Counters, sticky flag, first-mismatch capture and output pulses.
  always_comb begin
    chk_d    = chk_q;
    err_d    = err_q;
    sticky_d = sticky_q;
    fa_d     = fa_q;
    fb_d     = fb_q;
    fdut_d   = fdut_q;
    fexp_d   = fexp_q;
    flane_d  = flane_q;
    event_d  = comp_mis;
    drop_d   = reject;
    if (comp_any && chk_q != '1) chk_d = chk_q + CNT_WIDTH'(1);
    if (comp_mis) begin
      if (err_q != '1) err_d = err_q + CNT_WIDTH'(1);
      if (!sticky_q) begin
        sticky_d = 1'b1;
        fa_d     = comp_a;
        fb_d     = comp_b;
        fdut_d   = comp_dut;
        fexp_d   = comp_exp;
        flane_d  = comp_lane;
      end
    end
    // Clear wins for bookkeeping; the event pulse above is kept.
    if (i_clear) begin
      chk_d    = '0;
      err_d    = '0;
      sticky_d = 1'b0;
      fa_d     = '0;
      fb_d     = '0;
      fdut_d   = '0;
      fexp_d   = '0;
      flane_d  = '0;
    end
  end

  // Control and result state with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
    if (reset) begin
      ptr_q    <= '0;
      busy_q   <= '0;
      chk_q    <= '0;
      err_q    <= '0;
      sticky_q <= 1'b0;
      event_q  <= 1'b0;
      drop_q   <= 1'b0;
      fa_q     <= '0;
      fb_q     <= '0;
      fdut_q   <= '0;
      fexp_q   <= '0;
      flane_q  <= '0;
      for (int i = 0; i < NUM_LANES; i++) rem_q[i] <= '0;
    end else begin
      ptr_q    <= ptr_d;
      busy_q   <= busy_d;
      chk_q    <= chk_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      event_q  <= event_d;
      drop_q   <= drop_d;
      fa_q     <= fa_d;
      fb_q     <= fb_d;
      fdut_q   <= fdut_d;
      fexp_q   <= fexp_d;
      flane_q  <= flane_d;
      for (int i = 0; i < NUM_LANES; i++) rem_q[i] <= rem_d[i];
    end
  end

  // Lane payload storage.
  always_ff @(posedge clk) begin
    // NOTE: payload registers are not reset; they are only read while the lane's busy flag is set.
    for (int i = 0; i < NUM_LANES; i++) begin
      a_q[i]    <= a_d[i];
      b_q[i]    <= b_d[i];
      os_q[i]   <= os_d[i];
      mode_q[i] <= mode_d[i];
    end
  end

  assign o_event      = event_q;
  assign o_drop       = drop_q;
  assign o_busy       = |busy_q;
  assign o_chk_count  = chk_q;
  assign o_err_count  = err_q;
  assign o_err_sticky = sticky_q;
  assign o_first_a    = fa_q;
  assign o_first_b    = fb_q;
  assign o_first_dut  = fdut_q;
  assign o_first_exp  = fexp_q;
  assign o_first_lane = flane_q;

endmodule
